// File: rtl/vram_scroll_pkg.sv
// Shared definitions for the scrolling character VRAM: fill-engine state
// encoding, default blank cell value and a constant-safe clog2 helper.
// Build option: define VRAM_AUTOCLEAR_EN to clear the screen after reset.
package vram_scroll_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    localparam logic [5:0] BLANK_DEFAULT = 6'h20;

    // Minimum bit width that can index 'value' entries (at least 1).
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/vram_scroll_dp.sv
// Simple dual-port synchronous RAM, one write port and one read port,
// read-first on a same-address collision.
module vram_dp #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 960,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write and registered read; q holds while re is low.
    // NOTE: the array has no reset so it maps onto block RAM; contents are
    // defined only by writes. Non-blocking assignments make the read see
    // the pre-write value, which is what gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) q <= mem[raddr];
    end

endmodule

// File: rtl/vram_scroll.sv
// Character-cell VRAM with hardware scroll (row base offset) and a fill
// engine that blanks one row on scroll or the whole screen on clear.
// Build option: VRAM_AUTOCLEAR_EN starts a full clear right after reset.
module vram_scroll
    import vram_scroll_pkg::*;
#(
    parameter int                DATA_W = 6,
    parameter int                COLS   = 40,
    parameter int                ROWS   = 24,
    parameter logic [DATA_W-1:0] BLANK  = DATA_W'(BLANK_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rd_en,
    input  logic [clog2(ROWS)-1:0]   rd_row,
    input  logic [clog2(COLS)-1:0]   rd_col,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     wr_en,
    input  logic [clog2(ROWS)-1:0]   wr_row,
    input  logic [clog2(COLS)-1:0]   wr_col,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     scroll_req,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam int ROW_W  = clog2(ROWS);
    localparam int COL_W  = clog2(COLS);
    localparam int DEPTH  = ROWS * COLS;
    localparam int ADDR_W = clog2(DEPTH);

    localparam logic [ROW_W:0]    ROWS_EXT     = (ROW_W + 1)'(ROWS);
    localparam logic [ROW_W-1:0]  ROW_LAST     = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  COL_LAST     = COL_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] CNT_ROW_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] CNT_ALL_LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_nx;
    logic [ROW_W-1:0]  base_row;
    logic [ADDR_W-1:0] cnt;
    logic              fill_last;
    logic              auto_pend;
    logic              rd_sel;
    logic              rd_in_range, wr_in_range;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;

    // Logical row is rotated by base_row; the sum is below 2*ROWS so one
    // conditional subtract is the modulo.
    function automatic logic [ADDR_W-1:0] phys_addr(input logic [ROW_W-1:0] row,
                                                    input logic [ROW_W-1:0] base,
                                                    input logic [COL_W-1:0] col);
        logic [ROW_W:0] sum;
        sum = {1'b0, row} + {1'b0, base};
        if (sum >= ROWS_EXT) sum = sum - ROWS_EXT;
        return ADDR_W'(sum) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    assign rd_in_range = (rd_row <= ROW_LAST) && (rd_col <= COL_LAST);
    assign wr_in_range = (wr_row <= ROW_LAST) && (wr_col <= COL_LAST);

    assign fill_last = ((state == SCROLL) && (cnt == CNT_ROW_LAST)) ||
                       ((state == CLEAR)  && (cnt == CNT_ALL_LAST));

`ifdef VRAM_AUTOCLEAR_EN
    // Arm a one-shot clear that fires on the first cycle out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) auto_pend <= 1'b1;
        else        auto_pend <= 1'b0;
    end
`else
    assign auto_pend = 1'b0;
`endif

    // State, fill counter and scroll base registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            base_row <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE || fill_last) cnt <= '0;
            else                            cnt <= cnt + 1'b1;
            if (fill_last) begin
                if (state == CLEAR)          base_row <= '0;
                else if (base_row == ROW_LAST) base_row <= '0;
                else                         base_row <= base_row + 1'b1;
            end
        end
    end

    // Next-state: clear wins over scroll; requests while filling are dropped.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (clr_req || auto_pend) state_nx = CLEAR;
                else if (scroll_req)      state_nx = SCROLL;
            end
            SCROLL, CLEAR: begin
                if (fill_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs and write-port mux: the fill engine owns the RAM while busy.
    // NOTE: every output gets a default before the case so no latch is
    // inferred for paths that do not assign it.
    always_comb begin
        busy      = (state != IDLE);
        wr_ready  = (state == IDLE);
        ram_we    = 1'b0;
        ram_waddr = phys_addr(wr_row, base_row, wr_col);
        ram_wdata = wr_data;
        unique case (state)
            IDLE: ram_we = wr_en && wr_in_range;
            SCROLL: begin
                // Reset in mid-fill stops the engine before this cell.
                ram_we    = rst_n;
                ram_waddr = phys_addr('0, base_row, '0) + cnt;
                ram_wdata = BLANK;
            end
            CLEAR: begin
                ram_we    = rst_n;
                ram_waddr = cnt;
                ram_wdata = BLANK;
            end
            default: ram_we = 1'b0;
        endcase
    end

    // Remember whether the last accepted read hit a real cell.
    always_ff @(posedge clk) begin
        if (!rst_n)     rd_sel <= 1'b0;
        else if (rd_en) rd_sel <= rd_in_range;
    end

    assign rd_data = rd_sel ? ram_q : BLANK;

    vram_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_en && rd_in_range),
        .raddr (phys_addr(rd_row, base_row, rd_col)),
        .q     (ram_q)
    );

endmodule

// File: tb/tb_vram_scroll.sv
// Self-checking bench for vram_scroll (default 6-bit, 40x24 geometry).
// Honours VRAM_AUTOCLEAR_EN to expect the power-up clear.
module tb_vram_scroll;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd_en;
    logic [4:0] rd_row;
    logic [5:0] rd_col;
    logic [5:0] rd_data;
    logic       wr_en;
    logic [4:0] wr_row;
    logic [5:0] wr_col;
    logic [5:0] wr_data;
    logic       wr_ready;
    logic       scroll_req;
    logic       clr_req;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;

    vram_scroll dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .scroll_req (scroll_req),
        .clr_req    (clr_req),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [4:0] wr_row;
        logic [5:0] wr_col;
        logic [5:0] wr_data;
        logic       rd_en;
        logic [4:0] rd_row;
        logic [5:0] rd_col;
        logic [5:0] exp_rd;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_cell(input logic [4:0] r, input logic [5:0] c, output logic [5:0] d);
        rd_en = 1'b1; rd_row = r; rd_col = c;
        tick();
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic write_cell(input logic [4:0] r, input logic [5:0] c, input logic [5:0] d);
        wr_en = 1'b1; wr_row = r; wr_col = c; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    function automatic logic [5:0] pat(input int r, input int c);
        return 6'(((r * 40 + c) % 31) + 1);
    endfunction

    // Counts cells differing from the expectation: BLANK below blank_below,
    // the fill pattern at and above it (when use_pattern is set).
    task automatic count_bad(input logic use_pattern, input int blank_below, output int bad);
        logic [5:0] d, e;
        bad = 0;
        for (int r = 0; r < 24; r++) begin
            for (int c = 0; c < 40; c++) begin
                read_cell(5'(r), 6'(c), d);
                e = (use_pattern && (r * 40 + c >= blank_below)) ? pat(r, c) : 6'h20;
                if (d !== e) bad++;
            end
        end
    endtask

    task automatic count_busy(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 2000) begin
            cycles++;
            tick();
        end
    endtask

    task automatic run_fill(input logic do_scroll, input logic do_clr, output int cycles);
        scroll_req = do_scroll;
        clr_req    = do_clr;
        tick();
        scroll_req = 1'b0;
        clr_req    = 1'b0;
        count_busy(cycles);
    endtask

    initial begin
        int         cyc, bad;
        logic [5:0] d;

        rst_n = 1'b0; rd_en = 1'b0; rd_row = '0; rd_col = '0;
        wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        scroll_req = 1'b0; clr_req = 1'b0;

        //                wr    row    col    data   rd    row    col    expect
        vecs[0]  = '{1'b1, 5'd3,  6'd5,  6'h01, 1'b0, 5'd0,  6'd0,  6'h20};
        vecs[1]  = '{1'b0, 5'd0,  6'd0,  6'h00, 1'b1, 5'd3,  6'd5,  6'h01};
        vecs[2]  = '{1'b0, 5'd0,  6'd0,  6'h00, 1'b0, 5'd3,  6'd5,  6'h01};
        vecs[3]  = '{1'b1, 5'd3,  6'd5,  6'h2A, 1'b1, 5'd3,  6'd5,  6'h01};
        vecs[4]  = '{1'b0, 5'd0,  6'd0,  6'h00, 1'b1, 5'd3,  6'd5,  6'h2A};
        vecs[5]  = '{1'b1, 5'd24, 6'd0,  6'h15, 1'b0, 5'd0,  6'd0,  6'h2A};
        vecs[6]  = '{1'b0, 5'd0,  6'd0,  6'h00, 1'b1, 5'd0,  6'd0,  6'h20};
        vecs[7]  = '{1'b1, 5'd0,  6'd40, 6'h16, 1'b0, 5'd0,  6'd0,  6'h20};
        vecs[8]  = '{1'b0, 5'd0,  6'd0,  6'h00, 1'b1, 5'd1,  6'd0,  6'h20};
        vecs[9]  = '{1'b1, 5'd1,  6'd5,  6'h33, 1'b0, 5'd0,  6'd0,  6'h20};
        vecs[10] = '{1'b0, 5'd0,  6'd0,  6'h00, 1'b1, 5'd1,  6'd5,  6'h33};
        vecs[11] = '{1'b0, 5'd0,  6'd0,  6'h00, 1'b1, 5'd0,  6'd45, 6'h20};
        vecs[12] = '{1'b0, 5'd0,  6'd0,  6'h00, 1'b1, 5'd25, 6'd5,  6'h20};
        vecs[13] = '{1'b0, 5'd0,  6'd0,  6'h00, 1'b1, 5'd3,  6'd5,  6'h2A};
        vecs[14] = '{1'b1, 5'd23, 6'd39, 6'h3F, 1'b1, 5'd23, 6'd39, 6'h20};
        vecs[15] = '{1'b0, 5'd0,  6'd0,  6'h00, 1'b1, 5'd23, 6'd39, 6'h3F};

        // Reset values.
        repeat (3) tick();
        check("reset_rd_data", rd_data, 6'h20);
        check("reset_busy", busy, 1'b0);
        check("reset_wr_ready", wr_ready, 1'b1);
        rst_n = 1'b1;

`ifdef VRAM_AUTOCLEAR_EN
        tick();
        count_busy(cyc);
        check("autoclear_busy_cycles", cyc, 960);
        count_bad(1'b0, 0, bad);
        check("autoclear_cells_blank", bad, 0);
`else
        bad = 0;
        repeat (5) begin
            tick();
            if (busy !== 1'b0) bad++;
        end
        check("idle_after_reset", bad, 0);
`endif

        // Full clear from IDLE.
        run_fill(1'b0, 1'b1, cyc);
        check("clear_busy_cycles", cyc, 960);
        count_bad(1'b0, 0, bad);
        check("clear_cells_blank", bad, 0);

        // Single-cycle read/write vectors.
        foreach (vecs[i]) begin
            wr_en = vecs[i].wr_en; wr_row = vecs[i].wr_row;
            wr_col = vecs[i].wr_col; wr_data = vecs[i].wr_data;
            rd_en = vecs[i].rd_en; rd_row = vecs[i].rd_row; rd_col = vecs[i].rd_col;
            tick();
            check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_rd);
        end
        wr_en = 1'b0; rd_en = 1'b0;

        // Scroll with a write accepted in the request cycle; read mid-fill.
        wr_en = 1'b1; wr_row = 5'd1; wr_col = 6'd0; wr_data = 6'h11;
        scroll_req = 1'b1;
        tick();
        wr_en = 1'b0; scroll_req = 1'b0;
        check("scroll_wr_ready_low", wr_ready, 1'b0);
        rd_en = 1'b1; rd_row = 5'd1; rd_col = 6'd0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 2000) begin
            cyc++;
            tick();
            rd_en = 1'b0;
            if (cyc == 1) check("scroll_read_old_base", rd_data, 6'h11);
        end
        check("scroll_busy_cycles", cyc, 40);
        read_cell(5'd0, 6'd0, d);   check("scroll_row1_moved_up", d, 6'h11);
        read_cell(5'd23, 6'd0, d);  check("scroll_bottom_blank", d, 6'h20);
        read_cell(5'd2, 6'd5, d);   check("scroll_row3_moved_up", d, 6'h2A);
        read_cell(5'd22, 6'd39, d); check("scroll_row23_moved_up", d, 6'h3F);

        // Writes and requests during a scroll are dropped.
        scroll_req = 1'b1;
        tick();
        scroll_req = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 2000) begin
            cyc++;
            if (cyc == 3) begin
                wr_en = 1'b1; wr_row = 5'd5; wr_col = 6'd5; wr_data = 6'h07;
                clr_req = 1'b1; scroll_req = 1'b1;
            end
            tick();
            wr_en = 1'b0; clr_req = 1'b0; scroll_req = 1'b0;
        end
        check("busy_scroll_cycles", cyc, 40);
        tick();
        check("no_queued_request", busy, 1'b0);
        read_cell(5'd4, 6'd5, d); check("busy_write_dropped", d, 6'h20);
        read_cell(5'd1, 6'd5, d); check("second_scroll_shift", d, 6'h2A);

        // 24 scrolls: a marker on the last row reaches row 0, then vanishes.
        write_cell(5'd23, 6'd7, 6'h2B);
        bad = 0;
        for (int k = 1; k <= 24; k++) begin
            run_fill(1'b1, 1'b0, cyc);
            if (cyc != 40) bad++;
            if (k == 23) begin
                read_cell(5'd0, 6'd7, d);
                check("wrap_marker_at_top", d, 6'h2B);
            end
        end
        check("wrap_scroll_lengths", bad, 0);
        read_cell(5'd0, 6'd7, d);   check("wrap_marker_gone", d, 6'h20);
        read_cell(5'd23, 6'd7, d);  check("wrap_bottom_blank", d, 6'h20);

        // Simultaneous requests: clear wins.
        run_fill(1'b1, 1'b1, cyc);
        check("clear_priority_cycles", cyc, 960);

        // Reset at fill cycle 100 aborts the clear.
        for (int r = 0; r < 24; r++)
            for (int c = 0; c < 40; c++)
                write_cell(5'(r), 6'(c), pat(r, c));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        check("abort_busy", busy, 1'b0);
        check("abort_rd_data", rd_data, 6'h20);
        rst_n = 1'b1;
`ifdef VRAM_AUTOCLEAR_EN
        tick();
        count_busy(cyc);
        check("abort_autoclear_cycles", cyc, 960);
        count_bad(1'b0, 0, bad);
`else
        count_bad(1'b1, 100, bad);
`endif
        check("abort_cells", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
